// File: rtl/exc_pkg.sv
// Shared types and constants for the exception controller: FSM states,
// MIPS ExcCode values and CP0 register addresses ({cs,sel}).
package exc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_WR_EPC,
    S_WR_CAUSE,
    S_WR_STATUS,
    S_REDIRECT
  } state_t;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam logic [7:0] CP0_STATUS = 8'd96;
  localparam logic [7:0] CP0_CAUSE  = 8'd104;
  localparam logic [7:0] CP0_EPC    = 8'd112;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder: masked request bits -> {valid, ExcCode}.
// Priority: interrupt > overflow > syscall > break.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic [3:0] req,
  output logic       valid,
  output logic [4:0] code
);

  always_comb begin
    valid = 1'b1;
    code  = EXC_INT;
    if (req[0])      code = EXC_INT;
    else if (req[1]) code = EXC_OV;
    else if (req[2]) code = EXC_SYS;
    else if (req[3]) code = EXC_BP;
    else             valid = 1'b0;
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception / ERET sequencer: drains the pipe, writes EPC/Cause/Status over
// the CP0 port, then redirects the PC. Interrupts only with EXC_CTRL_IRQ_EN.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [29:0] HANDLER_PC   = 30'h0000_0400,
  parameter int          DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  exc_req,
  input  logic        eret_req,
  input  logic [29:0] exc_pc,
  input  logic [31:0] status_in,
  input  logic [31:0] epc_in,
  output logic        stall,
  output logic        flush,
  output logic        cp0_we,
  output logic [7:0]  cp0_waddr,
  output logic [31:0] cp0_wdata,
  output logic        redirect_valid,
  output logic [29:0] redirect_pc,
  output logic        busy
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [4:0]  code_q;
  logic [29:0] pc_q;
  logic [31:0] status_q;
  logic [29:0] epc_q;
  logic        eret_q;

  logic       ie, exl, irq, exc_valid, eret_ok, take;
  logic [3:0] req_m;
  logic [4:0] exc_code;
  logic       unused_bits;

  assign ie  = status_in[0];
  assign exl = status_in[1];

`ifdef EXC_CTRL_IRQ_EN
  assign irq = exc_req[0] & ie & ~exl;
`else
  assign irq = 1'b0;
`endif

  assign unused_bits = ^{epc_in[1:0], exc_req[0], ie};

  // EXL masks every source; with EXL=1 only an ERET can be taken.
  assign req_m   = {exc_req[3:1] & {3{~exl}}, irq};
  assign eret_ok = eret_req & exl;
  assign take    = (state == S_IDLE) & (exc_valid | eret_ok);

  exc_prio_enc u_enc (
    .req   (req_m),
    .valid (exc_valid),
    .code  (exc_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      code_q   <= '0;
      pc_q     <= '0;
      status_q <= '0;
      epc_q    <= '0;
      eret_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        cnt      <= DRAIN_LOAD;
        code_q   <= exc_code;
        pc_q     <= exc_pc;
        status_q <= status_in;
        epc_q    <= epc_in[31:2];
        eret_q   <= ~exc_valid;
      end else if (state == S_DRAIN && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Outputs decode the state register and latches only (Moore).
  always_comb begin
    state_nx       = state;
    stall          = 1'b1;
    busy           = 1'b1;
    flush          = 1'b0;
    cp0_we         = 1'b0;
    cp0_waddr      = '0;
    cp0_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      S_IDLE: begin
        stall = 1'b0;
        busy  = 1'b0;
        if (take) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        flush = 1'b1;
        if (cnt == 4'd0) state_nx = eret_q ? S_WR_STATUS : S_WR_EPC;
      end
      S_WR_EPC: begin
        cp0_we    = 1'b1;
        cp0_waddr = CP0_EPC;
        cp0_wdata = {pc_q, 2'b00};
        state_nx  = S_WR_CAUSE;
      end
      S_WR_CAUSE: begin
        cp0_we    = 1'b1;
        cp0_waddr = CP0_CAUSE;
        cp0_wdata = {25'd0, code_q, 2'b00};
        state_nx  = S_WR_STATUS;
      end
      S_WR_STATUS: begin
        cp0_we    = 1'b1;
        cp0_waddr = CP0_STATUS;
        cp0_wdata = eret_q ? (status_q & ~32'h2) : (status_q | 32'h2);
        state_nx  = S_REDIRECT;
      end
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = eret_q ? epc_q : HANDLER_PC;
        state_nx       = S_IDLE;
      end
      default: begin
        stall    = 1'b0;
        busy     = 1'b0;
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed vector table, hand-written reset/busy cases
// and random transactions against a rule-level model of the sequence.
module tb_exc_ctrl;

  localparam int          DC = 2;
  localparam logic [29:0] HPC = 30'h0000_0400;
`ifdef EXC_CTRL_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  exc_req;
  logic        eret_req;
  logic [29:0] exc_pc;
  logic [31:0] status_in, epc_in;
  logic        stall, flush, cp0_we, redirect_valid, busy;
  logic [7:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [29:0] redirect_pc;

  exc_ctrl #(.HANDLER_PC(HPC), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .exc_req(exc_req), .eret_req(eret_req),
    .exc_pc(exc_pc), .status_in(status_in), .epc_in(epc_in),
    .stall(stall), .flush(flush), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr),
    .cp0_wdata(cp0_wdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall, flush, we;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        rv;
    logic [29:0] rpc;
    logic        busy;
  } out_t;

  // kind: 0 = ignored, 1 = exception, 2 = ERET
  typedef struct {
    logic [3:0]  req;
    logic        eret;
    logic [29:0] pc;
    logic [31:0] st, epc;
    int          kind;
    logic [31:0] cause, stat;
    logic [29:0] rpc;
    bit          hold;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  out_t exp_q[$];
  vec_t tbl[12];

  function automatic out_t cyc(logic s, logic f, logic w, logic [7:0] a,
                               logic [31:0] d, logic r, logic [29:0] p, logic b);
    out_t o;
    o = '{stall: s, flush: f, we: w, addr: a, data: d, rv: r, rpc: p, busy: b};
    return o;
  endfunction

  function automatic vec_t mkv(logic [3:0] req, logic eret, logic [29:0] pc,
                               logic [31:0] st, logic [31:0] epc, int kind,
                               logic [31:0] cause, logic [31:0] stat,
                               logic [29:0] rpc, bit hold);
    vec_t v;
    v = '{req: req, eret: eret, pc: pc, st: st, epc: epc, kind: kind,
          cause: cause, stat: stat, rpc: rpc, hold: hold};
    return v;
  endfunction

  function automatic out_t sample();
    out_t o;
    o = cyc(stall, flush, cp0_we, cp0_waddr, cp0_wdata, redirect_valid,
            redirect_pc, busy);
    return o;
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got st=%b fl=%b we=%b a=%0d d=%h rv=%b rpc=%h busy=%b exp st=%b fl=%b we=%b a=%0d d=%h rv=%b rpc=%h busy=%b",
               name, got.stall, got.flush, got.we, got.addr, got.data, got.rv, got.rpc, got.busy,
               exp.stall, exp.flush, exp.we, exp.addr, exp.data, exp.rv, exp.rpc, exp.busy);
    end
  endtask

  // Expected per-cycle trace from the moment the request is accepted.
  task automatic build(input int kind, input logic [29:0] pc,
                       input logic [31:0] cause, input logic [31:0] stat,
                       input logic [29:0] rpc);
    exp_q.delete();
    if (kind == 0) return;
    for (int i = 0; i < DC; i++) exp_q.push_back(cyc(1, 1, 0, 0, 0, 0, 0, 1));
    if (kind == 1) begin
      exp_q.push_back(cyc(1, 0, 1, 8'd112, {pc, 2'b00}, 0, 0, 1));
      exp_q.push_back(cyc(1, 0, 1, 8'd104, cause, 0, 0, 1));
    end
    exp_q.push_back(cyc(1, 0, 1, 8'd96, stat, 0, 0, 1));
    exp_q.push_back(cyc(1, 0, 0, 0, 0, 1, rpc, 1));
  endtask

  // Rule-level reference: eligibility, priority and write values.
  task automatic model(input logic [3:0] req, input logic eret,
                       input logic [31:0] st, input logic [31:0] epc,
                       output int kind, output logic [31:0] cause,
                       output logic [31:0] stat, output logic [29:0] rpc);
    bit irq, ie, exl;
    int code;
    ie = st[0]; exl = st[1];
    irq = IRQ_EN && req[0] && ie && !exl;
    kind = 0; cause = 0; stat = 0; rpc = 0;
    if (!exl && (irq || req[3:1] != 3'b000)) begin
      kind = 1;
      if (irq)         code = 0;
      else if (req[1]) code = 12;
      else if (req[2]) code = 8;
      else             code = 9;
      cause = 32'(code * 4);
      stat  = st | 32'h2;
      rpc   = HPC;
    end else if (eret && exl) begin
      kind = 2;
      stat = st & ~32'h2;
      rpc  = epc[31:2];
    end
  endtask

  // Called at a negedge; drives the request and checks trace + 2 idle cycles.
  task automatic run_txn(input string name, input logic [3:0] req,
                         input logic eret, input logic [29:0] pc,
                         input logic [31:0] st, input logic [31:0] epc,
                         input bit hold);
    int n;
    exc_req = req; eret_req = eret; exc_pc = pc; status_in = st; epc_in = epc;
    n = exp_q.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      check(name, sample(), (i < n) ? exp_q[i] : out_t'('0));
      if (!hold || i >= n - 1) begin
        exc_req = 4'b0; eret_req = 1'b0;
      end
    end
  endtask

  initial begin
    int          kind;
    logic [31:0] cause, stat, st, epc;
    logic [29:0] rpc, pc;
    logic [3:0]  req;
    logic        eret;

    rst = 1'b1; exc_req = 4'b0; eret_req = 1'b0; exc_pc = '0;
    status_in = '0; epc_in = '0;
    // A request under reset must stay invisible.
    exc_req = 4'b0100;
    repeat (2) @(negedge clk);
    check("reset", sample(), '0);
    exc_req = 4'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", sample(), '0);

    tbl[0]  = mkv(4'b0100, 0, 30'h40,  32'h0, 32'h0, 1, 32'h20, 32'h2, HPC, 0);
    tbl[1]  = mkv(4'b0010, 0, 30'h123, 32'h0, 32'h0, 1, 32'h30, 32'h2, HPC, 0);
    tbl[2]  = mkv(4'b1000, 0, 30'h3FFF_FFFF, 32'h1, 32'h0, 1, 32'h24, 32'h3, HPC, 0);
    if (IRQ_EN) tbl[3] = mkv(4'b1011, 0, 30'h55, 32'h1, 32'h0, 1, 32'h0,  32'h3, HPC, 0);
    else        tbl[3] = mkv(4'b1011, 0, 30'h55, 32'h1, 32'h0, 1, 32'h30, 32'h3, HPC, 0);
    tbl[4]  = mkv(4'b0001, 0, 30'h10,  32'h0, 32'h0, 0, 0, 0, 0, 0);
    tbl[5]  = mkv(4'b0100, 0, 30'h10,  32'h2, 32'h0, 0, 0, 0, 0, 0);
    if (IRQ_EN) tbl[6] = mkv(4'b0001, 0, 30'h77, 32'h1, 32'h0, 1, 32'h0, 32'h3, HPC, 0);
    else        tbl[6] = mkv(4'b0001, 0, 30'h77, 32'h1, 32'h0, 0, 0, 0, 0, 0);
    tbl[7]  = mkv(4'b0000, 1, 30'h0,   32'h3, 32'h200, 2, 0, 32'h1, 30'h80, 0);
    tbl[8]  = mkv(4'b0000, 1, 30'h0,   32'h0, 32'h200, 0, 0, 0, 0, 0);
    tbl[9]  = mkv(4'b0100, 1, 30'h9,   32'hFF02, 32'h1004, 2, 0, 32'hFF00, 30'h401, 0);
    tbl[10] = mkv(4'b0100, 1, 30'h9,   32'h0, 32'h1004, 1, 32'h20, 32'h2, HPC, 0);
    // Request held high through the whole sequence: taken once only.
    tbl[11] = mkv(4'b1000, 0, 30'h200, 32'h0, 32'h0, 1, 32'h24, 32'h2, HPC, 1);

    foreach (tbl[k]) begin
      build(tbl[k].kind, tbl[k].pc, tbl[k].cause, tbl[k].stat, tbl[k].rpc);
      run_txn($sformatf("vec%0d", k), tbl[k].req, tbl[k].eret, tbl[k].pc,
              tbl[k].st, tbl[k].epc, tbl[k].hold);
    end

    // Reset during WR_CAUSE: no Status write, no redirect afterwards.
    build(1, 30'h40, 32'h20, 32'h2, HPC);
    exc_req = 4'b0100; exc_pc = 30'h40; status_in = 32'h0;
    for (int i = 0; i < DC + 2; i++) begin
      @(negedge clk);
      check("mid_rst_pre", sample(), exp_q[i]);
      exc_req = 4'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_zero", sample(), '0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_after", sample(), '0);
    end

    for (int t = 0; t < 150; t++) begin
      req  = 4'($urandom);
      eret = 1'($urandom);
      pc   = 30'($urandom);
      st   = $urandom;
      epc  = $urandom;
      model(req, eret, st, epc, kind, cause, stat, rpc);
      build(kind, pc, cause, stat, rpc);
      run_txn($sformatf("rand%0d", t), req, eret, pc, st, epc, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 The block SHALL have parameter HANDLER_PC, default 30'h0000_0400, the word address of the exception handler.
REQ-002 The block SHALL have parameter DRAIN_CYCLES, default 2, range 1..15, the number of cycles it waits for in-flight pipeline stages to settle.
REQ-003 Port: clk  in  1  sole clock, rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: exc_req  in  4  request bits: [0] external interrupt, [1] overflow, [2] syscall, [3] break.
REQ-006 Port: eret_req  in  1  ERET decoded in ID.
REQ-007 Port: exc_pc  in  30  word PC of the faulting or interrupted instruction.
REQ-008 Port: status_in  in  32  current CP0 Status (address 96); bit0 = IE, bit1 = EXL.
REQ-009 Port: epc_in  in  32  current CP0 EPC (address 112).
REQ-010 Port: stall  out  1  freeze PC and the IF/ID stages.
REQ-011 Port: flush  out  1  bubble the ID/EX/MEM stages.
REQ-012 Port: cp0_we, cp0_waddr, cp0_wdata  out  1/8/32  CP0 write port; address = {cs,sel}.
REQ-013 Port: redirect_valid, redirect_pc  out  1/30  one-cycle PC override.
REQ-014 Port: busy  out  1  FSM not in IDLE.

Function
REQ-015 FSM states SHALL be IDLE, DRAIN, WR_EPC, WR_CAUSE, WR_STATUS and REDIRECT; all outputs are Moore outputs registered from state, with no combinational input-to-output path.
REQ-016 Requests SHALL be sampled only in IDLE; requests in any other state are ignored, not queued.
REQ-017 An interrupt SHALL be eligible only when IE=1 and EXL=0; synchronous exceptions are eligible only when EXL=0.
REQ-018 Priority among eligible exceptions SHALL be: interrupt > overflow > syscall > break; ExcCode values are 0, 12, 8 and 9 respectively.
REQ-019 An ERET SHALL be accepted only when EXL=1; an ERET with EXL=0 is ignored.
REQ-020 With EXL=1 exceptions are ineligible, so exception and ERET acceptance SHALL be mutually exclusive.
REQ-021 On acceptance the block SHALL latch the code, exc_pc, status_in and epc_in, and enter DRAIN on the same edge.
REQ-022 DRAIN SHALL last exactly DRAIN_CYCLES cycles, using a 4-bit down-counter.
REQ-023 Exception path: DRAIN -> WR_EPC -> WR_CAUSE -> WR_STATUS -> REDIRECT -> IDLE, each state after DRAIN lasting one cycle.
REQ-024 In WR_EPC the block SHALL write address 112 with {pc,2'b00}.
REQ-025 In WR_CAUSE the block SHALL write address 104 with code<<2 and all other bits 0.
REQ-026 In WR_STATUS the block SHALL write address 96 with the latched status and bit1 set to 1.
REQ-027 In REDIRECT the exception path SHALL drive redirect_pc = HANDLER_PC.
REQ-028 ERET path: DRAIN -> WR_STATUS (latched status with bit1 cleared to 0) -> REDIRECT (redirect_pc = latched epc[31:2]) -> IDLE.
REQ-029 stall and busy SHALL be 1 in every non-IDLE state; flush SHALL be 1 in DRAIN only; cp0_we SHALL be 1 in WR_* states only.
REQ-030 The exception sequence SHALL occupy DRAIN_CYCLES+4 cycles and the ERET sequence DRAIN_CYCLES+2 cycles.
REQ-031 When cp0_we=0, cp0_waddr and cp0_wdata SHALL be 0.

Reset
REQ-032 While rst=1 the FSM SHALL go to IDLE, the counter and latches clear to 0, and all outputs are 0.
REQ-033 A reset arriving mid-sequence SHALL abort it with no further CP0 write or redirect.

Configuration
REQ-034 With macro EXC_CTRL_IRQ_EN defined, exc_req[0] SHALL participate per REQ-017 and REQ-018.
REQ-035 Without EXC_CTRL_IRQ_EN, exc_req[0] SHALL be ignored and interrupts are never taken; all other behaviour is unchanged.

Structure
REQ-036 Package exc_pkg SHALL hold the state enum, the ExcCode constants (0/8/9/12) and the CP0 address constants (EPC=112, CAUSE=104, STATUS=96).
REQ-037 Sub-module exc_prio_enc SHALL be combinational and map the masked exc_req to {valid, code}.

Verification (DRAIN_CYCLES=2)
REQ-038 Syscall: exc_req=4'b0100, exc_pc=30'h40, status=0 -> 2 flush cycles, then writes (112,32'h100), (104,32'h20), (96,32'h2), then redirect_pc=30'h400; busy for 6 cycles.
REQ-039 Simultaneous: exc_req=4'b1011 with IE=1, EXL=0 -> Cause written with 0 (interrupt); overflow and break dropped.
REQ-040 Masking: exc_req=4'b0001 with IE=0, and exc_req=4'b0100 with EXL=1 -> no busy and no write; with the macro undefined, IE=1 and exc_req=4'b0001 -> no action.
REQ-041 ERET: EXL=1, status=32'h3, epc=32'h200 -> write (96,32'h1), then redirect_pc=30'h80; busy for 4 cycles; ERET with EXL=0 -> ignored.
REQ-042 Mid-sequence: rst pulsed in WR_CAUSE -> next cycle all outputs 0, no Status write; exc_req asserted while busy -> ignored.
